// File: rtl/pusch_pkg.sv
// pusch_pkg: shared constants, FSM state and LFSR step helpers for the PUSCH scrambler.
// SCRAMBLER_FASTWARM_EN shortens warm-up to NC/4 cycles of 4 steps each.
package pusch_pkg;
  localparam int NC = 1600;
  localparam int LFSR_W = 31;
`ifdef SCRAMBLER_FASTWARM_EN
  localparam int WARM_CYC = NC / 4;
`else
  localparam int WARM_CYC = NC;
`endif
  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
  function automatic logic [LFSR_W-1:0] x1_adv(input logic [LFSR_W-1:0] x);
    return {x[3] ^ x[0], x[LFSR_W-1:1]};
  endfunction
  function automatic logic [LFSR_W-1:0] x2_adv(input logic [LFSR_W-1:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[LFSR_W-1:1]};
  endfunction
endpackage

// File: rtl/gold_seq_gen.sv
// gold_seq_gen: x1/x2 LFSR pair producing Gold sequence bit c = x1[0]^x2[0].
// SCRAMBLER_FASTWARM_EN adds a step4 input advancing both registers four positions.
module gold_seq_gen
  import pusch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] c_init,
  input  logic              step,
`ifdef SCRAMBLER_FASTWARM_EN
  input  logic              step4,
`endif
  output logic              c
);
  logic [LFSR_W-1:0] x1_q, x1_d, x2_q, x2_d;
  // bit i of each register holds x(n+i); shifting right advances n
  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    if (load) begin
      x1_d = LFSR_W'(1);
      x2_d = c_init;
    end
`ifdef SCRAMBLER_FASTWARM_EN
    else if (step4) begin
      x1_d = x1_adv(x1_adv(x1_adv(x1_adv(x1_q))));
      x2_d = x2_adv(x2_adv(x2_adv(x2_adv(x2_q))));
    end
`endif
    else if (step) begin
      x1_d = x1_adv(x1_q);
      x2_d = x2_adv(x2_q);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1_q <= '0;
      x2_q <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
    end
  end
  assign c = x1_q[0] ^ x2_q[0];
endmodule

// File: rtl/pusch_scrambler.sv
// pusch_scrambler: XORs incoming bits with the NR Gold sequence after a 1600-step warm-up.
// SCRAMBLER_FASTWARM_EN runs the warm-up at 4 steps per cycle; output is unchanged.
module pusch_scrambler
  import pusch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Active,
  input  logic [15:0] n_RNTI,
  input  logic [9:0]  n_ID,
  input  logic [16:0] E,
  input  logic        data_in,
  input  logic        valid_in,
  output logic        ready,
  output logic        data_out,
  output logic        valid_out,
  output logic        done
);
  state_t state_q, state_d;
  logic [16:0] cnt_q, cnt_d, e_q, e_d;
  logic [10:0] warm_q, warm_d;
  logic data_out_q, data_out_d, valid_out_q, valid_out_d, done_q, done_d;
  logic c, step, warming, warm_end, accept, last;
`ifdef SCRAMBLER_FASTWARM_EN
  logic step4;
`endif
  gold_seq_gen u_gold (
    .clk    (clk),
    .reset  (reset),
    .load   (Active),
    .c_init ({n_RNTI, 5'b0, n_ID}),
    .step   (step),
`ifdef SCRAMBLER_FASTWARM_EN
    .step4  (step4),
`endif
    .c      (c)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (Active) state_d = WARMUP;
    else if (warm_end) state_d = (e_q == '0) ? IDLE : RUN;
    else if (accept && last) state_d = IDLE;
  end
  // a new Active takes priority over any bit offered in the same cycle
  always_comb begin
    ready = (state_q == RUN) && !Active;
    accept = ready && valid_in;
    last = cnt_q == e_q - 17'd1;
    warming = (state_q == WARMUP) && !Active;
    warm_end = warming && (warm_q == 11'(WARM_CYC - 1));
`ifdef SCRAMBLER_FASTWARM_EN
    step = accept;
    step4 = warming;
`else
    step = warming || accept;
`endif
    warm_d = warming ? warm_q + 11'd1 : '0;
    cnt_d = Active ? '0 : accept ? cnt_q + 17'd1 : cnt_q;
    e_d = Active ? E : e_q;
    data_out_d = accept ? data_in ^ c : 1'b0;
    valid_out_d = accept;
    done_d = (accept && last) || (warm_end && e_q == '0);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      e_q <= '0;
      warm_q <= '0;
      data_out_q <= 1'b0;
      valid_out_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      e_q <= e_d;
      warm_q <= warm_d;
      data_out_q <= data_out_d;
      valid_out_q <= valid_out_d;
      done_q <= done_d;
    end
  end
  assign data_out = data_out_q;
  assign valid_out = valid_out_q;
  assign done = done_q;
endmodule

// File: tb/tb_pusch_scrambler.sv
// tb_pusch_scrambler: random scoreboard bench against a direct Gold-sequence reference model.
module tb_pusch_scrambler;
`ifdef SCRAMBLER_FASTWARM_EN
  localparam int WARM = 400;
`else
  localparam int WARM = 1600;
`endif
  logic clk = 1'b0, reset = 1'b0, Active = 1'b0, data_in = 1'b0, valid_in = 1'b0;
  logic [15:0] n_RNTI = '0;
  logic [9:0] n_ID = '0;
  logic [16:0] E = '0;
  logic ready, data_out, valid_out, done;
  int cmp = 0, errs = 0, ecur = 0;
  bit exp_done_alone = 0;
  logic [1:0] exp_q[$];
  bit gold_q[$];
  bit x1a[4000], x2a[4000];

  pusch_scrambler dut (
    .clk(clk), .reset(reset), .Active(Active), .n_RNTI(n_RNTI), .n_ID(n_ID), .E(E),
    .data_in(data_in), .valid_in(valid_in), .ready(ready), .data_out(data_out),
    .valid_out(valid_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // c(n) straight from its definition: x sequences by recurrence, offset by Nc=1600
  task automatic make_gold(input logic [30:0] ci, input int len);
    int m = 1600 + len + 31;
    for (int i = 0; i < 31; i++) begin
      x1a[i] = (i == 0);
      x2a[i] = ci[i];
    end
    for (int n = 0; n + 31 < m; n++) begin
      x1a[n+31] = x1a[n+3] ^ x1a[n];
      x2a[n+31] = x2a[n+3] ^ x2a[n+2] ^ x2a[n+1] ^ x2a[n];
    end
    gold_q.delete();
    for (int n = 0; n < len; n++) gold_q.push_back(x1a[n+1600] ^ x2a[n+1600]);
  endtask

  task automatic start(input logic [15:0] r, input logic [9:0] id, input int e);
    @(posedge clk); #1;
    Active = 1'b1; n_RNTI = r; n_ID = id; E = 17'(e); valid_in = 1'b0;
    ecur = e;
    make_gold({r, 5'b0, id}, e);
    @(posedge clk); #1;
    Active = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!ready && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 32'(k), 32'(WARM));
  endtask

  // vmode: 0 always valid, 1 alternate cycles, 2 random; dmode: 0/1 constant, 2 random
  task automatic send(input int limit, input int vmode, input int dmode);
    int n = 0, guard = 0;
    logic v, d;
    while (n < limit && guard < 20000) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? logic'(guard % 2 == 0) : logic'($urandom_range(3) != 0);
      d = (dmode == 2) ? logic'($urandom_range(1)) : logic'(dmode);
      valid_in = v;
      data_in = d;
      if (v && ready) begin
        exp_q.push_back({d ^ logic'(gold_q[n]), logic'(n == ecur - 1)});
        n++;
      end
      guard++;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    if (n < limit) chk("send_timeout", 32'(n), 32'(limit));
  endtask

  initial begin : monitor
    logic [1:0] it;
    forever begin
      @(posedge clk); #1;
      if (valid_out) begin
        if (exp_q.size() == 0) chk("unexpected_valid_out", 32'(valid_out), 32'(0));
        else begin
          it = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(it[1]));
          chk("done_with_bit", 32'(done), 32'(it[0]));
        end
      end else if (done) begin
        chk("done_alone", 32'(done), 32'(exp_done_alone));
        exp_done_alone = 0;
      end
    end
  end

  initial begin : stim
    int rhigh;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b1;

    start(16'h0000, 10'd0, 8);
    wait_ready("warm_latency_e8");
    send(8, 0, 0);

    start(16'h4601, 10'h1F5, 64);
    wait_ready("warm_latency_e64");
    send(64, 1, 1);

    start(16'h1234, 10'd99, 0);
    exp_done_alone = 1;
    rhigh = 0;
    repeat (WARM + 5) begin
      @(posedge clk); #1;
      if (ready) rhigh++;
    end
    chk("e0_ready_never", 32'(rhigh), 0);
    chk("e0_done_seen", 32'(exp_done_alone), 0);

    start(16'($urandom), 10'($urandom), 100);
    wait_ready("warm_latency_abort1");
    send(10, 0, 2);
    start(16'($urandom), 10'd7, 100);
    wait_ready("warm_latency_abort2");
    send(100, 0, 2);

    start(16'($urandom), 10'($urandom), 50);
    wait_ready("warm_latency_rst");
    send(5, 0, 2);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_data_out", 32'(data_out), 0);
    chk("midrst_valid_out", 32'(valid_out), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_queue", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    valid_in = 1'b1;
    rhigh = 0;
    repeat (30) begin
      data_in = logic'($urandom_range(1));
      @(posedge clk); #1;
      if (ready) rhigh++;
    end
    valid_in = 1'b0;
    chk("postrst_ready_never", 32'(rhigh), 0);

    start(16'($urandom), 10'($urandom), 1000);
    wait_ready("warm_latency_e1000");
    send(1000, 2, 2);

    start(16'hFFFF, 10'd1023, 1);
    wait_ready("warm_latency_e1");
    send(1, 2, 2);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/pusch_scrambler.md
PUSCH_SCRAMBLER -- requirements
Module: pusch_scrambler

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising-edge active.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Active, input, 1, single-cycle start pulse for one codeword.
REQ-004 SHALL have port n_RNTI, input, 16, RNTI; sampled only on Active.
REQ-005 SHALL have port n_ID, input, 10, scrambling ID 0..1023; sampled only on Active.
REQ-006 SHALL have port E, input, 17, number of bits to scramble; sampled only on Active.
REQ-007 SHALL have port data_in, input, 1, interleaved bit from the bit interleaver.
REQ-008 SHALL have port valid_in, input, 1, data_in qualifier.
REQ-009 SHALL have port ready, output, 1, high when a bit is accepted this cycle.
REQ-010 SHALL have port data_out, output, 1, scrambled bit to the modulation mapper.
REQ-011 SHALL have port valid_out, output, 1, data_out qualifier.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last bit is output.

Function
REQ-013 SHALL generate the length-31 Gold sequence c(n) = (x1(n+1600) + x2(n+1600)) mod 2.
- x1 feedback taps 3,0; x2 feedback taps 3,2,1,0.
REQ-014 SHALL initialise x1 = 1 (bit0 set, rest 0) and x2 = c_init = n_RNTI*2^15 + n_ID.
- c_init held as 31 bits; n_RNTI bit15 sets c_init bit30.
REQ-015 SHALL implement the FSM IDLE -> WARMUP -> RUN -> IDLE.
REQ-016 IDLE: ready=0; Active loads the LFSRs, latches E, and moves to WARMUP.
REQ-017 WARMUP: advance both LFSRs one step per cycle, 1600 steps total; ready=0; valid_in ignored.
REQ-018 After warm-up, SHALL enter RUN with ready=1; if latched E=0, SHALL instead pulse done and return to IDLE.
REQ-019 RUN: on valid_in&ready, data_out = data_in XOR c(n) is registered (latency 1 cycle), valid_out=1, the LFSRs advance and the bit counter increments.
REQ-020 In RUN, cycles without valid_in SHALL NOT advance the LFSRs; valid_out=0.
REQ-021 On acceptance of bit E-1: ready drops the following cycle, done pulses in the same cycle as the last valid_out, and the FSM returns to IDLE.
REQ-022 Active in WARMUP or RUN SHALL abort the current codeword, reload with the new inputs, and re-enter WARMUP; no done pulse for the aborted codeword.
REQ-023 The bit counter SHALL be 17 bits and SHALL NOT wrap; the maximum E of 131071 SHALL be supported.

Reset
REQ-024 Reset low SHALL immediately force: IDLE, ready=0, data_out=0, valid_out=0, done=0, LFSRs=0, counter=0.
REQ-025 Reset asserted mid-codeword SHALL discard the codeword; after release the block SHALL wait for Active.

Configuration
REQ-026 With macro SCRAMBLER_FASTWARM_EN defined, WARMUP SHALL advance the LFSRs 4 steps per cycle, lasting 400 cycles.
- RUN is unchanged.
- Without the macro, WARMUP advances 1 step per cycle (1600 cycles).
- Output sequences SHALL be bit-identical in both builds.

Structure
REQ-027 Package pusch_pkg SHALL hold NC=1600, LFSR_W=31, the FSM state enum, and the warm-up cycle-count constant.
REQ-028 The LFSR pair plus c(n) output SHALL be a sub-module gold_seq_gen with inputs load, c_init, and step.
- When SCRAMBLER_FASTWARM_EN is defined, gold_seq_gen SHALL also have a step4 input.
REQ-029 pusch_scrambler SHALL contain the FSM, counter, and output register.

Verification
REQ-030 Active with n_RNTI=0, n_ID=0, E=8, data_in=0: ready rises 1600 cycles after Active (400 with macro); data_out equals the golden c(0..7); done pulses once.
REQ-031 Active with n_RNTI=0x4601, n_ID=0x1F5, E=64, data_in=1 with valid_in toggling every other cycle: data_out equals ~c(n) for all 64 bits; gaps do not advance the sequence; done aligns with the 64th valid_out.
REQ-032 E=0: no valid_out; done pulses right after warm-up; FSM returns to IDLE.
REQ-033 Active reissued at RUN bit 10 of E=100 with n_ID=7: no done for the first codeword; the output restarts from c(0) of the new c_init after a full warm-up.
REQ-034 Reset pulled low at RUN bit 5: all outputs become 0 within the same cycle; after release, valid_in is ignored until Active.
REQ-035 The macro-on and macro-off builds, run with identical random stimulus (E=1000), SHALL produce identical data_out streams.
